dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the byte-address width of all address ports.
REQ-002 Parameter DATA_W, default 32, shall set the data width of all data ports.
REQ-003 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  shall be the reset: asynchronous, active-high.
REQ-005 cpu_read  in  1  MEM-stage load request.
REQ-006 cpu_write  in  2  MEM-stage store size: 00 none, 01 byte, 10 half, 11 word.
REQ-007 cpu_addr  in  ADDR_W  CPU byte address.
REQ-008 cpu_wdata  in  DATA_W  CPU store data.
REQ-009 cpu_rdata  out  DATA_W  CPU load data, registered.
REQ-010 cpu_stall  out  1  holds the pipeline while the CPU access is incomplete.
REQ-011 cpu_fault  out  1  one-cycle pulse on a misaligned CPU access.
REQ-012 ld_req, ld_we  in  1 each  loader/DMA request and write flag; loader accesses are word only.
REQ-013 ld_addr, ld_wdata  in  ADDR_W / DATA_W  loader address and data.
REQ-014 ld_gnt, ld_rvalid  out  1 each  loader accepted this cycle; loader read data valid.
REQ-015 ld_rdata  out  DATA_W  loader read data.
REQ-016 mem_read, mem_write  out  1 / 2  memory strobes, mem_write using the cpu_write encoding.
REQ-017 mem_addr, mem_wdata  out  ADDR_W / DATA_W  memory address and data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_read.

Function
REQ-019 A CPU request shall exist when cpu_read=1 or cpu_write!=00; when both are set, the write shall take precedence and the read shall be ignored.
REQ-020 The FSM shall have states IDLE, CPU_RESP and LD_RESP; grants shall be issued only in IDLE.
REQ-021 In IDLE with one requester, that requester shall be granted; with both, the requester not granted last (last_gnt register) shall win.
REQ-022 Granted access shall drive mem_* combinationally in the grant cycle; ungranted cycles shall drive mem_read=0, mem_write=00.
REQ-023 Loader grant: ld_gnt=1 in that cycle; mem_write=11 if ld_we, else mem_read=1; ld_addr[1:0] forced to 00 on mem_addr.
REQ-024 CPU write grant: a single-cycle access with cpu_stall=0 in the grant cycle; the FSM shall stay in IDLE.
REQ-025 CPU read grant: cpu_stall=1 in the grant cycle, then CPU_RESP; in CPU_RESP, cpu_rdata shall load mem_rdata at the closing edge, cpu_stall=0, and no new grant shall be issued; CPU_RESP->IDLE.
REQ-026 Loader read: ld_rvalid=1 and ld_rdata=mem_rdata combinationally in LD_RESP; LD_RESP->IDLE.
REQ-027 A CPU request that is pending but not granted (including in CPU_RESP/LD_RESP when it is not the completing read) shall assert cpu_stall=1.
REQ-028 Misalignment (half with addr[0]=1, word with addr[1:0]!=00, read treated as word):
  - no memory access is issued and the FSM stays in IDLE;
  - the CPU consumes the grant slot in that IDLE cycle;
  - cpu_fault=1 and cpu_stall=0 for that cycle.
REQ-029 cpu_rdata shall hold its value until the next completed CPU read.
REQ-030 last_gnt shall update on every grant, including faulted CPU grants.

Reset
REQ-031 Asserting rst shall immediately set:
  - state: IDLE; last_gnt: LOADER (CPU wins the first tie);
  - cpu_rdata: 0; all strobes, cpu_stall, cpu_fault, ld_gnt, ld_rvalid: 0.
REQ-032 Reset mid-read shall discard the in-flight data; no rvalid or cpu_rdata update shall follow.

Structure
REQ-033 Package dmem_pkg shall hold the MW_NONE/MW_BYTE/MW_HALF/MW_WORD constants and the state enum.
REQ-034 Two-way round-robin selection shall be one sub-module, dmem_rr_pick (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-035 CPU word read of 0x10, mem returns 0xDEADBEEF: stall 1 then 0; cpu_rdata=0xDEADBEEF after cycle 2.
REQ-036 CPU store-byte and loader write requested together from reset: CPU granted in cycle 1 (stall 0), loader in cycle 2 (ld_gnt 1).
REQ-037 Both requesting continuously for 6 cycles: grants alternate; neither waits more than 2 cycles.
REQ-038 CPU half write to 0x03: cpu_fault pulses one cycle, mem_write stays 00, stall 0.
REQ-039 Loader read of 0x22: mem_addr=0x20; ld_rvalid 1 one cycle later with mem_rdata.
REQ-040 rst asserted in CPU_RESP: outputs zero immediately, cpu_rdata=0, IDLE after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared store-size encodings, arbiter states and last-grant codes for dmem_arbiter.
package dmem_pkg;
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;
  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_LD  = 1'b1;
  typedef enum logic [1:0] {IDLE, CPU_RESP, LD_RESP} state_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin pick; req[0]=cpu, req[1]=loader, last=1 means loader won last, gnt one-hot or zero.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory port between the CPU MEM stage (cpu_*) and a word-only loader (ld_*), driving mem_* and returning read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [1:0]        cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_fault,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_read,
  output logic [1:0]        mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic last_gnt;
  logic [1:0] gnt;
  logic [1:0] cpu_size;
  logic cpu_wr, cpu_req, cpu_mis, idle, g_cpu, g_ld, cpu_rd_go, ld_rd_go;
  assign cpu_wr = |cpu_write;
  assign cpu_req = cpu_read | cpu_wr;
  // a plain load is checked as a word access
  assign cpu_size = cpu_wr ? cpu_write : MW_WORD;
  assign cpu_mis = ((cpu_size == MW_HALF) & cpu_addr[0]) | ((cpu_size == MW_WORD) & (|cpu_addr[1:0]));
  // rst gates every combinational output so they drop the moment reset rises
  assign idle = ~rst & (state == IDLE);
  dmem_rr_pick u_pick (
    .req ({ld_req, cpu_req}),
    .last(last_gnt),
    .gnt (gnt)
  );
  assign g_cpu = idle & gnt[0];
  assign g_ld = idle & gnt[1];
  assign cpu_rd_go = g_cpu & ~cpu_wr & ~cpu_mis;
  assign ld_rd_go = g_ld & ~ld_we;
  always_comb begin
    mem_read = cpu_rd_go | ld_rd_go;
    mem_write = g_ld ? (ld_we ? MW_WORD : MW_NONE) : (g_cpu & cpu_wr & ~cpu_mis) ? cpu_write : MW_NONE;
    mem_addr = g_ld ? {ld_addr[ADDR_W-1:2], 2'b00} : cpu_addr;
    mem_wdata = g_ld ? ld_wdata : cpu_wdata;
    ld_gnt = g_ld;
    cpu_fault = g_cpu & cpu_mis;
    ld_rvalid = ~rst & (state == LD_RESP);
    ld_rdata = mem_rdata;
    // CPU_RESP is always the completing read, so the CPU is released there
    cpu_stall = ~rst & cpu_req & ((state == LD_RESP) | ((state == IDLE) & (~g_cpu | cpu_rd_go)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_gnt <= LAST_LD;
      cpu_rdata <= '0;
    end else begin
      if (state == CPU_RESP) cpu_rdata <= mem_rdata;
      if (g_cpu | g_ld) last_gnt <= g_ld ? LAST_LD : LAST_CPU;
      state <= cpu_rd_go ? CPU_RESP : ld_rd_go ? LD_RESP : IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table vectors, directed multi-cycle sequences and random stimulus against a reference model for dmem_arbiter.
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_read = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [1:0] cpu_write = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ld_addr = '0, ld_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
  logic cpu_stall, cpu_fault, ld_gnt, ld_rvalid, mem_read;
  logic [1:0] mem_write;
  int total = 0, bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cr; logic [1:0] cw; logic [31:0] ca; logic lr; logic lw; logic [31:0] la;
    logic st; logic fa; logic gn; logic mr; logic [1:0] mw; logic [31:0] ma;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [31:0] ectl(logic rv, logic st, logic fa, logic gn, logic mr, logic [1:0] mw);
    return {25'b0, rv, st, fa, gn, mr, mw};
  endfunction

  function automatic logic [31:0] act_ctl();
    return {25'b0, ld_rvalid, cpu_stall, cpu_fault, ld_gnt, mem_read, mem_write};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic cr, input logic [1:0] cw, input logic [31:0] ca, input logic lr, input logic lw, input logic [31:0] la);
    cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = $urandom;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = $urandom;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    drv(0, 2'b00, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
  endtask

  // reference model state
  int pend;
  bit clast;
  logic [31:0] m_rdata;
  logic e_st, e_fa, e_gn, e_mr, e_rv;
  logic [1:0] e_mw;
  logic [31:0] e_ma, e_md;

  task automatic model_eval();
    bit creq, wr, mis, to_cpu, to_ld;
    logic [1:0] sz;
    creq = cpu_read || cpu_write != 2'b00;
    wr = cpu_write != 2'b00;
    sz = wr ? cpu_write : 2'b11;
    mis = (sz == 2'b10 && cpu_addr[0]) || (sz == 2'b11 && cpu_addr[1:0] != 2'b00);
    {e_st, e_fa, e_gn, e_mr, e_rv} = '0;
    e_mw = 2'b00; e_ma = '0; e_md = '0;
    to_cpu = 0; to_ld = 0;
    if (pend == 1) e_st = 0;
    else if (pend == 2) begin
      e_rv = 1;
      e_st = creq;
    end else begin
      if (creq && ld_req) begin
        to_cpu = !clast; to_ld = clast;
      end else begin
        to_cpu = creq; to_ld = ld_req;
      end
      if (to_cpu) begin
        if (mis) e_fa = 1;
        else if (wr) begin e_mw = cpu_write; e_ma = cpu_addr; e_md = cpu_wdata; end
        else begin e_mr = 1; e_st = 1; e_ma = cpu_addr; end
      end else if (to_ld) begin
        e_gn = 1;
        e_st = creq;
        e_ma = ld_addr & 32'hFFFF_FFFC;
        if (ld_we) begin e_mw = 2'b11; e_md = ld_wdata; end
        else e_mr = 1;
      end else e_st = creq;
    end
    chk("rnd_ctl", act_ctl(), ectl(e_rv, e_st, e_fa, e_gn, e_mr, e_mw));
    chk("rnd_rdata", cpu_rdata, m_rdata);
    if (e_mr || e_mw != 2'b00) chk("rnd_addr", mem_addr, e_ma);
    if (e_mw != 2'b00) chk("rnd_wdata", mem_wdata, e_md);
    if (e_rv) chk("rnd_ld_rdata", ld_rdata, mem_rdata);
    if (pend == 1) m_rdata = mem_rdata;
    if (to_cpu || to_ld) clast = to_cpu;
    pend = (to_cpu && !wr && !mis) ? 1 : (to_ld && !ld_we) ? 2 : 0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'b01, 32'h41,  1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h41};
    tbl[1]  = '{1'b0, 2'b00, 32'h0,   1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h80};
    tbl[2]  = '{1'b0, 2'b11, 32'h100, 1'b1, 1'b1, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h100};
    tbl[3]  = '{1'b0, 2'b11, 32'h104, 1'b1, 1'b1, 32'h88, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h88};
    tbl[4]  = '{1'b0, 2'b11, 32'h104, 1'b1, 1'b1, 32'h8F, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h104};
    tbl[5]  = '{1'b0, 2'b11, 32'h108, 1'b1, 1'b1, 32'h8F, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h8C};
    tbl[6]  = '{1'b0, 2'b11, 32'h108, 1'b1, 1'b1, 32'h90, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 32'h108};
    tbl[7]  = '{1'b0, 2'b10, 32'h3,   1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
    tbl[8]  = '{1'b0, 2'b10, 32'h2,   1'b1, 1'b1, 32'h91, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 32'h90};
    tbl[9]  = '{1'b0, 2'b10, 32'h2,   1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h2};
    tbl[10] = '{1'b0, 2'b11, 32'h6,   1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
    tbl[11] = '{1'b0, 2'b01, 32'h7,   1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h7};
    tbl[12] = '{1'b1, 2'b01, 32'h9,   1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h9};
    tbl[13] = '{1'b1, 2'b00, 32'h12,  1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0};
    tbl[14] = '{1'b0, 2'b00, 32'h0,   1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};

    // reset with both requesters active: everything must stay quiet
    drv(1, 2'b00, 32'h10, 1, 1, 32'h40);
    #3;
    chk("reset_ctl", act_ctl(), 32'h0);
    chk("reset_rdata", cpu_rdata, 32'h0);
    do_reset();

    // table: arbitration, alternation and alignment rules from reset
    foreach (tbl[i]) begin
      drv(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].lr, tbl[i].lw, tbl[i].la);
      #2;
      chk($sformatf("tbl%0d_ctl", i), act_ctl(), ectl(1'b0, tbl[i].st, tbl[i].fa, tbl[i].gn, tbl[i].mr, tbl[i].mw));
      if (tbl[i].mr || tbl[i].mw != 2'b00) chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].ma);
      cyc();
    end

    // CPU word read of 0x10
    do_reset();
    drv(1, 2'b00, 32'h10, 0, 0, 0);
    mem_rdata = 32'h0;
    #2;
    chk("rd_grant_ctl", act_ctl(), ectl(0, 1, 0, 0, 1, 2'b00));
    chk("rd_grant_addr", mem_addr, 32'h10);
    cyc();
    mem_rdata = 32'hDEADBEEF;
    drv(1, 2'b00, 32'h10, 1, 1, 32'h40);
    #2;
    chk("rd_resp_ctl", act_ctl(), ectl(0, 0, 0, 0, 0, 2'b00));
    cyc();
    drv(0, 2'b00, 0, 0, 0, 0);
    mem_rdata = 32'h11111111;
    #2;
    chk("rd_data", cpu_rdata, 32'hDEADBEEF);
    cyc();
    #2;
    chk("rd_hold", cpu_rdata, 32'hDEADBEEF);

    // loader read of 0x22, CPU store waits through LD_RESP
    cyc();
    drv(0, 2'b00, 0, 1, 0, 32'h22);
    #2;
    chk("ldrd_ctl", act_ctl(), ectl(0, 0, 0, 1, 1, 2'b00));
    chk("ldrd_addr", mem_addr, 32'h20);
    cyc();
    drv(0, 2'b01, 32'h5, 0, 0, 0);
    mem_rdata = 32'h12345678;
    #2;
    chk("ldresp_ctl", act_ctl(), ectl(1, 1, 0, 0, 0, 2'b00));
    chk("ldresp_data", ld_rdata, 32'h12345678);
    cyc();
    #2;
    chk("after_ld_ctl", act_ctl(), ectl(0, 0, 0, 0, 0, 2'b01));
    chk("after_ld_addr", mem_addr, 32'h5);

    // reset while in CPU_RESP
    cyc();
    drv(1, 2'b00, 32'h20, 0, 0, 0);
    #2;
    chk("rst_rd_grant", act_ctl(), ectl(0, 1, 0, 0, 1, 2'b00));
    cyc();
    mem_rdata = 32'hCAFEF00D;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", act_ctl(), 32'h0);
    chk("rst_mid_rdata", cpu_rdata, 32'h0);
    cyc();
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_after_rdata", cpu_rdata, 32'h0);
    chk("rst_after_idle", act_ctl(), ectl(0, 1, 0, 0, 1, 2'b00));

    // random traffic against the model
    do_reset();
    pend = 0; clast = 0; m_rdata = '0;
    e_st = 0; e_gn = 0;
    for (int n = 0; n < 600; n++) begin
      if (!e_st) begin
        int op;
        op = $urandom_range(0, 3);
        cpu_read = op == 1 || op == 3;
        cpu_write = op >= 2 ? 2'($urandom_range(1, 3)) : 2'b00;
        cpu_addr = 32'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
      if (!(ld_req && !e_gn)) begin
        ld_req = 1'($urandom_range(0, 1));
        ld_we = 1'($urandom_range(0, 1));
        ld_addr = 32'($urandom_range(0, 255));
        ld_wdata = $urandom;
      end
      mem_rdata = $urandom;
      #2;
      model_eval();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
